dcache_wb_buffer: RTL and testbench

//  Write-back (victim) buffer downstream of the dcache data array. Accepts dirty

---
 rtl/dcache_wb_buffer_pkg.sv | 31 +++
 rtl/dcache_wb_buffer_cam.sv | 28 ++
 rtl/dcache_wb_buffer.sv | 110 +++++++++++
 tb/tb_dcache_wb_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wb_buffer_pkg.sv
// dcache_wb_buffer_pkg: shared geometry, bus command encoding and entry layout for the write-back buffer
//   DCACHE_INDEX_SIZE / DCACHE_TAG_SIZE / DCACHE_BLOCK_SIZE : cache geometry
//   DCACHE_WB_DEPTH : default buffer depth
//   bus_command_t   : memory bus command encoding
//   wb_entry_t      : one buffered victim block
//   wb_addr()       : block byte address {zero-ext, tag, index, 3'b000}
package dcache_wb_buffer_pkg;
    localparam int DCACHE_INDEX_SIZE = 5;
    localparam int DCACHE_TAG_SIZE   = 8;
    localparam int DCACHE_BLOCK_SIZE = 64;
    localparam int DCACHE_WB_DEPTH   = 4;
    localparam int WB_KEY_W          = DCACHE_TAG_SIZE + DCACHE_INDEX_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    typedef struct packed {
        logic                         valid;
        logic [DCACHE_TAG_SIZE-1:0]   tag;
        logic [DCACHE_INDEX_SIZE-1:0] index;
        logic [DCACHE_BLOCK_SIZE-1:0] data;
    } wb_entry_t;

    function automatic logic [63:0] wb_addr(input logic [DCACHE_TAG_SIZE-1:0] tag,
                                            input logic [DCACHE_INDEX_SIZE-1:0] index);
        return 64'({tag, index, 3'b000});
    endfunction
endpackage

// File: rtl/dcache_wb_buffer_cam.sv
// wb_cam_match: DEPTH-way {tag,index} compare giving a one-hot hit vector and encoded position
//   keys    in  per-entry {tag,index}
//   mask    in  entries allowed to match
//   key     in  probe {tag,index}
//   hit_vec out one-hot match vector (at most one bit set)
//   pos     out index of the matching entry (0 when none)
module wb_cam_match
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH = DCACHE_WB_DEPTH
) (
    input  logic [DEPTH-1:0][WB_KEY_W-1:0] keys,
    input  logic [DEPTH-1:0]               mask,
    input  logic [WB_KEY_W-1:0]            key,
    output logic [DEPTH-1:0]               hit_vec,
    output logic [$clog2(DEPTH)-1:0]       pos
);
    localparam int PW = $clog2(DEPTH);

    always_comb begin
        hit_vec = '0;
        pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = mask[i] && keys[i] == key;
            pos = hit_vec[i] ? PW'(i) : pos;
        end
    end
endmodule

// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: in-order victim buffer that drains dirty blocks to memory and forwards them to load-miss probes
//   clock, reset (async, active-low)
//   enq_valid/enq_index/enq_tag/enq_data, enq_ready : victim block enqueue (merges onto an existing {tag,index})
//   lookup_valid/lookup_index/lookup_tag -> lookup_hit/lookup_data : zero-latency probe of buffered blocks
//   mem_port_free, mem2wb_response -> wb2mem_command/addr/data : head-of-queue store issue and retire
//   wb_count, wb_empty : occupancy
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH = DCACHE_WB_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq_valid,
    input  logic [DCACHE_INDEX_SIZE-1:0] enq_index,
    input  logic [DCACHE_TAG_SIZE-1:0]   enq_tag,
    input  logic [DCACHE_BLOCK_SIZE-1:0] enq_data,
    output logic                         enq_ready,
    input  logic                         lookup_valid,
    input  logic [DCACHE_INDEX_SIZE-1:0] lookup_index,
    input  logic [DCACHE_TAG_SIZE-1:0]   lookup_tag,
    output logic                         lookup_hit,
    output logic [DCACHE_BLOCK_SIZE-1:0] lookup_data,
    input  logic                         mem_port_free,
    output bus_command_t                 wb2mem_command,
    output logic [63:0]                  wb2mem_addr,
    output logic [DCACHE_BLOCK_SIZE-1:0] wb2mem_data,
    input  logic [3:0]                   mem2wb_response,
    output logic [$clog2(DEPTH):0]       wb_count,
    output logic                         wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0]               buf_q, buf_d;
    logic      [DEPTH-1:0][WB_KEY_W-1:0] keys;
    logic      [DEPTH-1:0]               valid_mask, retire_mask, merge_vec, lookup_vec;
    logic      [PW-1:0]                  head_q, head_d, tail_q, tail_d, merge_pos, lookup_pos;
    logic      [CW-1:0]                  count_q, count_d;
    logic                                issue, retire, enq_fire, merge_hit;

    always_comb begin
        keys = '0;
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keys[i] = {buf_q[i].tag, buf_q[i].index};
            valid_mask[i] = buf_q[i].valid;
        end
    end

    assign enq_ready   = count_q != CW'(DEPTH);
    assign issue       = count_q != '0 && mem_port_free;
    assign retire      = issue && mem2wb_response != '0;
    assign enq_fire    = enq_valid && enq_ready;
    assign retire_mask = DEPTH'(retire) << head_q;

    // The head being retired this edge is excluded so a re-eviction of it allocates a fresh slot.
    wb_cam_match #(.DEPTH(DEPTH)) u_merge_cam (
        .keys    (keys),
        .mask    (valid_mask & ~retire_mask),
        .key     ({enq_tag, enq_index}),
        .hit_vec (merge_vec),
        .pos     (merge_pos)
    );

    wb_cam_match #(.DEPTH(DEPTH)) u_lookup_cam (
        .keys    (keys),
        .mask    (valid_mask),
        .key     ({lookup_tag, lookup_index}),
        .hit_vec (lookup_vec),
        .pos     (lookup_pos)
    );

    assign merge_hit      = |merge_vec;
    assign lookup_hit     = lookup_valid && |lookup_vec;
    assign lookup_data    = lookup_hit ? buf_q[lookup_pos].data : '0;
    assign wb2mem_command = issue ? BUS_STORE : BUS_NONE;
    assign wb2mem_addr    = issue ? wb_addr(buf_q[head_q].tag, buf_q[head_q].index) : '0;
    assign wb2mem_data    = issue ? buf_q[head_q].data : '0;
    assign wb_count       = count_q;
    assign wb_empty       = count_q == '0;

    always_comb begin
        buf_d = buf_q;
        head_d = retire ? head_q + PW'(1) : head_q;
        tail_d = enq_fire && !merge_hit ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(enq_fire && !merge_hit) - CW'(retire);
        if (retire)
            buf_d[head_q].valid = 1'b0;
        // Tail never aliases a retiring head: a non-full buffer with a head to retire has tail != head.
        if (enq_fire && merge_hit)
            buf_d[merge_pos].data = enq_data;
        else if (enq_fire)
            buf_d[tail_q] = '{valid: 1'b1, tag: enq_tag, index: enq_index, data: enq_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            buf_q <= buf_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: scoreboard bench driving directed and random traffic against a queue-level model
module tb_dcache_wb_buffer;
    import dcache_wb_buffer_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  tag;
        logic [4:0]  idx;
        logic [63:0] data;
    } ent_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         enq_valid, lookup_valid, mem_port_free;
    logic [4:0]   enq_index, lookup_index;
    logic [7:0]   enq_tag, lookup_tag;
    logic [63:0]  enq_data;
    logic         enq_ready, lookup_hit, wb_empty;
    logic [63:0]  lookup_data, wb2mem_addr, wb2mem_data;
    bus_command_t wb2mem_command;
    logic [3:0]   mem2wb_response;
    logic [2:0]   wb_count;

    ent_t q[$];
    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;

    dcache_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_index       (enq_index),
        .enq_tag         (enq_tag),
        .enq_data        (enq_data),
        .enq_ready       (enq_ready),
        .lookup_valid    (lookup_valid),
        .lookup_index    (lookup_index),
        .lookup_tag      (lookup_tag),
        .lookup_hit      (lookup_hit),
        .lookup_data     (lookup_data),
        .mem_port_free   (mem_port_free),
        .wb2mem_command  (wb2mem_command),
        .wb2mem_addr     (wb2mem_addr),
        .wb2mem_data     (wb2mem_data),
        .mem2wb_response (mem2wb_response),
        .wb_count        (wb_count),
        .wb_empty        (wb_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] blk_addr(input ent_t e);
        return 64'(e.tag) * 256 + 64'(e.idx) * 8;
    endfunction

    task automatic idle_inputs();
        enq_valid = 0; enq_tag = 0; enq_index = 0; enq_data = 0;
        lookup_valid = 0; lookup_tag = 0; lookup_index = 0;
        mem_port_free = 0; mem2wb_response = 0;
    endtask

    // One clock cycle: drive at the falling edge, check against the model, then advance the model.
    task automatic step(input bit ev, input logic [7:0] t, input logic [4:0] ix, input logic [63:0] d,
                        input bit free, input logic [3:0] resp,
                        input bit lv, input logic [7:0] lt, input logic [4:0] li);
        bit full, iss, hit;
        logic [63:0] ld, ea, ed;
        int m;
        @(negedge clock);
        enq_valid = ev; enq_tag = t; enq_index = ix; enq_data = d;
        mem_port_free = free; mem2wb_response = resp;
        lookup_valid = lv; lookup_tag = lt; lookup_index = li;
        #1;
        full = q.size() >= DEPTH;
        iss = q.size() != 0 && free;
        ea = 0; ed = 0;
        if (iss) begin
            ea = blk_addr(q[0]);
            ed = q[0].data;
        end
        hit = 0; ld = 0;
        if (lv)
            foreach (q[i])
                if (q[i].tag == lt && q[i].idx == li) begin
                    hit = 1;
                    ld = q[i].data;
                end
        chk("wb_count", 64'(wb_count), 64'(q.size()));
        chk("wb_empty", 64'(wb_empty), 64'(q.size() == 0));
        chk("enq_ready", 64'(enq_ready), 64'(!full));
        chk("command", 64'(wb2mem_command), iss ? 64'(BUS_STORE) : 64'(BUS_NONE));
        chk("issue_addr", wb2mem_addr, ea);
        chk("issue_data", wb2mem_data, ed);
        chk("lookup_hit", 64'(lookup_hit), 64'(hit));
        chk("lookup_data", lookup_data, ld);
        if (iss && resp != 0)
            exp_q.push_back(q.pop_front());
        if (ev && !full) begin
            m = -1;
            foreach (q[i])
                if (q[i].tag == t && q[i].idx == ix)
                    m = i;
            if (m >= 0)
                q[m].data = d;
            else
                q.push_back('{t, ix, d});
        end
    endtask

    task automatic enq(input logic [7:0] t, input logic [4:0] ix, input logic [63:0] d);
        step(1, t, ix, d, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_cyc(input bit free, input logic [3:0] resp, input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, free, resp, 0, 0, 0);
    endtask

    // Monitor: every store the DUT completes must be the next one the model retired.
    initial forever begin
        @(negedge clock);
        #2;
        if (reset && wb2mem_command == BUS_STORE && mem2wb_response != 0) begin
            chk("store_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("store_addr", wb2mem_addr, blk_addr(mon_e));
                chk("store_data", wb2mem_data, mon_e.data);
            end
        end
    end

    initial begin
        idle_inputs();
        reset = 0;
        #1;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_lookup_hit", 64'(lookup_hit), 64'd0);
        chk("rst_command", 64'(wb2mem_command), 64'(BUS_NONE));
        chk("rst_addr", wb2mem_addr, 64'd0);
        chk("rst_data", wb2mem_data, 64'd0);
        chk("rst_count", 64'(wb_count), 64'd0);
        chk("rst_empty", 64'(wb_empty), 64'd1);
        #12 reset = 1;

        // Asynchronous reset while draining three entries.
        enq(8'h01, 5'd1, 64'h11);
        enq(8'h02, 5'd2, 64'h22);
        enq(8'h03, 5'd3, 64'h33);
        wait_cyc(1, 0, 2);
        #2 reset = 0;
        #1;
        chk("midrst_command", 64'(wb2mem_command), 64'(BUS_NONE));
        chk("midrst_count", 64'(wb_count), 64'd0);
        chk("midrst_empty", 64'(wb_empty), 64'd1);
        q.delete();
        exp_q.delete();
        idle_inputs();
        @(negedge clock);
        #3 reset = 1;
        wait_cyc(0, 0, 1);

        // Single entry issued and retired immediately.
        enq(8'h12, 5'd5, 64'hAA);
        wait_cyc(1, 3, 1);
        wait_cyc(0, 0, 1);

        // Fill, stall with zero responses, ignore a fifth enqueue, then retire one.
        for (int i = 0; i < 4; i++)
            enq(8'h20 + 8'(i), 5'(i), 64'h100 + 64'(i));
        step(1, 8'h30, 5'd9, 64'hDEAD, 1, 0, 0, 0, 0);
        wait_cyc(1, 0, 2);
        wait_cyc(1, 1, 1);
        wait_cyc(0, 0, 1);
        wait_cyc(1, 1, 4);

        // Merge: A, B, A' leaves two entries, A carries new data, order A then B.
        enq(8'h40, 5'd1, 64'h1);
        enq(8'h41, 5'd2, 64'hB);
        enq(8'h40, 5'd1, 64'h2);
        step(0, 0, 0, 0, 0, 0, 1, 8'h40, 5'd1);
        wait_cyc(1, 1, 3);

        // Full buffer with simultaneous enqueue and retire.
        for (int i = 0; i < 4; i++)
            enq(8'h50 + 8'(i), 5'(i), 64'h500 + 64'(i));
        step(1, 8'h60, 5'd7, 64'hBEEF, 1, 2, 0, 0, 0);
        wait_cyc(0, 0, 1);
        wait_cyc(1, 1, 4);

        // Memory port busy for ten cycles, probing the second entry each cycle.
        enq(8'h70, 5'd3, 64'h70);
        enq(8'h71, 5'd4, 64'h71);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 0, 1, 1, 8'h71, 5'd4);
        wait_cyc(1, 1, 3);

        // Pointer wrap: nine enqueue/retire pairs.
        for (int i = 0; i < 9; i++)
            step(1, 8'h80 + 8'(i), 5'(i), 64'h800 + 64'(i), 1, 1, 1, 8'h80 + 8'(i), 5'(i));
        wait_cyc(1, 1, 2);

        // Random traffic over a small key space so merges and lookup hits are frequent.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 {$urandom, $urandom}, $urandom_range(0, 99) < 60, 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 15)),
                 $urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));

        wait_cyc(1, 1, 8);
        #3;
        chk("all_stores_seen", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
